// File: rtl/cop0_exception_unit.sv
// Exception front end for COP0: IRQ synchronisation and pending latch, fault/interrupt
// prioritisation and the registered exception-capture strobe with cause code and BD flag.
module cop0_exception_unit #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       iCLK,
   input  logic       iCLR,
   input  logic [7:0] iIRQ,
   input  logic [7:0] iIRQAck,
   input  logic       iInstrBoundary,
   input  logic       iAddrErrLoad,
   input  logic       iAddrErrStore,
   input  logic       iReservedInstr,
   input  logic       iSyscall,
   input  logic       iBreak,
   input  logic       iOverflow,
   input  logic       iBranchDelayIn,
   input  logic [7:0] iInterruptMask,
   input  logic       iExcLevel,
   input  logic       iEret,
   output logic [7:0] oPendingInterrupt,
   output logic       oExcOccurred,
   output logic [4:0] oExcCode,
   output logic       oBranchDelay,
   output logic       oInterrupted
);

   localparam logic [4:0] CodeInt  = 5'd0;
   localparam logic [4:0] CodeAdEL = 5'd4;
   localparam logic [4:0] CodeAdES = 5'd5;
   localparam logic [4:0] CodeSys  = 5'd8;
   localparam logic [4:0] CodeBp   = 5'd9;
   localparam logic [4:0] CodeRI   = 5'd10;
   localparam logic [4:0] CodeOv   = 5'd12;

   typedef enum logic [1:0] {StIdle, StExc, StHandler} stateT;

   stateT stateQ, stateD;

   logic [SYNC_STAGES-1:0][7:0] syncQ;
   logic [7:0] syncPrevQ;
   logic [7:0] pendingQ;
   logic [7:0] irqRise;

   logic       excQ, excD;
   logic [4:0] codeQ, codeD;
   logic       bdQ, bdD;
   logic       intQ, intD;

   logic       fault;
   logic [4:0] faultCode;
   logic       irqReq;

   // Rising edge of the synchronised line; a held level sets pending only once.
   assign irqRise = syncQ[SYNC_STAGES-1] & ~syncPrevQ;

   always_ff @(posedge iCLK or posedge iCLR) begin
      if (iCLR) begin
         syncQ     <= '0;
         syncPrevQ <= '0;
         pendingQ  <= '0;
      end else begin
         syncQ     <= {syncQ[SYNC_STAGES-2:0], iIRQ};
         syncPrevQ <= syncQ[SYNC_STAGES-1];
         pendingQ  <= (pendingQ & ~iIRQAck) | irqRise;
      end
   end

   always_comb begin
      fault     = 1'b1;
      faultCode = CodeInt;
      if (iAddrErrLoad) begin
         faultCode = CodeAdEL;
      end else if (iAddrErrStore) begin
         faultCode = CodeAdES;
      end else if (iReservedInstr) begin
         faultCode = CodeRI;
      end else if (iSyscall) begin
         faultCode = CodeSys;
      end else if (iBreak) begin
         faultCode = CodeBp;
      end else if (iOverflow) begin
         faultCode = CodeOv;
      end else begin
         fault = 1'b0;
      end
   end

   assign irqReq = iInstrBoundary & ~iExcLevel & (|iInterruptMask);

   always_comb begin
      stateD = stateQ;
      excD   = 1'b0;
      codeD  = CodeInt;
      bdD    = 1'b0;
      intD   = 1'b0;
      case (stateQ)
         StIdle: begin
            if (fault) begin
               excD  = 1'b1;
               codeD = faultCode;
               bdD   = iBranchDelayIn;
            end else if (irqReq) begin
               excD = 1'b1;
               intD = 1'b1;
            end
         end
         StExc: begin
            stateD = StHandler;
         end
         StHandler: begin
            // Nested faults still report; interrupts wait for eret.
            if (fault) begin
               excD  = 1'b1;
               codeD = faultCode;
               bdD   = iBranchDelayIn;
            end else if (iEret) begin
               stateD = StIdle;
            end
         end
         default: begin
            stateD = StIdle;
         end
      endcase
      if (excD) begin
         stateD = StExc;
      end
   end

   always_ff @(posedge iCLK or posedge iCLR) begin
      if (iCLR) begin
         stateQ <= StIdle;
         excQ   <= 1'b0;
         codeQ  <= CodeInt;
         bdQ    <= 1'b0;
         intQ   <= 1'b0;
      end else begin
         stateQ <= stateD;
         excQ   <= excD;
         codeQ  <= codeD;
         bdQ    <= bdD;
         intQ   <= intD;
      end
   end

   assign oPendingInterrupt = pendingQ;
   assign oExcOccurred      = excQ;
   assign oExcCode          = codeQ;
   assign oBranchDelay      = bdQ;
   assign oInterrupted      = intQ;

endmodule

// File: tb/tb_cop0_exception_unit.sv
// Bench for cop0_exception_unit: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a behavioural model.
module tb_cop0_exception_unit;

   localparam int unsigned S = 2;

   logic       iCLK = 1'b0;
   logic       iCLR;
   logic [7:0] iIRQ;
   logic [7:0] iIRQAck;
   logic       iInstrBoundary;
   logic       iAddrErrLoad;
   logic       iAddrErrStore;
   logic       iReservedInstr;
   logic       iSyscall;
   logic       iBreak;
   logic       iOverflow;
   logic       iBranchDelayIn;
   logic [7:0] iInterruptMask;
   logic       iExcLevel;
   logic       iEret;
   logic [7:0] oPendingInterrupt;
   logic       oExcOccurred;
   logic [4:0] oExcCode;
   logic       oBranchDelay;
   logic       oInterrupted;

   cop0_exception_unit #(.SYNC_STAGES(S)) dut (
      .iCLK              (iCLK),
      .iCLR              (iCLR),
      .iIRQ              (iIRQ),
      .iIRQAck           (iIRQAck),
      .iInstrBoundary    (iInstrBoundary),
      .iAddrErrLoad      (iAddrErrLoad),
      .iAddrErrStore     (iAddrErrStore),
      .iReservedInstr    (iReservedInstr),
      .iSyscall          (iSyscall),
      .iBreak            (iBreak),
      .iOverflow         (iOverflow),
      .iBranchDelayIn    (iBranchDelayIn),
      .iInterruptMask    (iInterruptMask),
      .iExcLevel         (iExcLevel),
      .iEret             (iEret),
      .oPendingInterrupt (oPendingInterrupt),
      .oExcOccurred      (oExcOccurred),
      .oExcCode          (oExcCode),
      .oBranchDelay      (oBranchDelay),
      .oInterrupted      (oInterrupted)
   );

   always #5 iCLK = ~iCLK;

   int nTests = 0;
   int nFail  = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      nTests++;
      if (got !== exp) begin
         nFail++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, exp);
      end
   endtask

   // Behavioural model: IRQ sample history, pending set, and a three-mode exception tracker.
   localparam int ModeIdle = 0, ModeExc = 1, ModeHandler = 2;
   logic [7:0] hist [S+1];
   logic [7:0] mPend;
   int         mode;
   logic       mOcc, mInt, mBd;
   logic [4:0] mCode;
   int         codeTab [6] = '{4, 5, 10, 8, 9, 12};

   task automatic modelStep();
      logic [7:0] rise;
      logic [5:0] fv;
      int         first;
      // hist[j] holds the iIRQ value sampled j+1 edges ago
      rise = hist[S-1] & ~hist[S];
      for (int k = S; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = iIRQ;
      mPend = (mPend & ~iIRQAck) | rise;

      fv = {iOverflow, iBreak, iSyscall, iReservedInstr, iAddrErrStore, iAddrErrLoad};
      first = -1;
      for (int k = 5; k >= 0; k--) if (fv[k]) first = k;
      mOcc = 1'b0; mInt = 1'b0; mBd = 1'b0; mCode = 5'd0;
      if (mode == ModeExc) begin
         mode = ModeHandler;
      end else if (first >= 0) begin
         mOcc = 1'b1; mCode = 5'(codeTab[first]); mBd = iBranchDelayIn; mode = ModeExc;
      end else if (mode == ModeIdle && iInstrBoundary && !iExcLevel && iInterruptMask != 0) begin
         mOcc = 1'b1; mInt = 1'b1; mode = ModeExc;
      end else if (mode == ModeHandler && iEret) begin
         mode = ModeIdle;
      end
   endtask

   always @(posedge iCLK) begin
      if (iCLR) begin
         for (int k = 0; k <= S; k++) hist[k] = 8'h00;
         mPend = 8'h00; mode = ModeIdle;
         mOcc = 1'b0; mInt = 1'b0; mBd = 1'b0; mCode = 5'd0;
      end else begin
         modelStep();
      end
      #1;
      check("model_pending", 32'(oPendingInterrupt), 32'(mPend));
      check("model_exc", 32'(oExcOccurred), 32'(mOcc));
      check("model_code", 32'(oExcCode), 32'(mCode));
      check("model_bd", 32'(oBranchDelay), 32'(mBd));
      check("model_int", 32'(oInterrupted), 32'(mInt));
   end

   task automatic clearIn();
      iIRQAck = 8'h00; iInstrBoundary = 1'b0; iAddrErrLoad = 1'b0; iAddrErrStore = 1'b0;
      iReservedInstr = 1'b0; iSyscall = 1'b0; iBreak = 1'b0; iOverflow = 1'b0;
      iBranchDelayIn = 1'b0; iInterruptMask = 8'h00; iExcLevel = 1'b0; iEret = 1'b0;
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge iCLK);
   endtask

   task automatic toIdle();
      clearIn();
      cyc(2);
      iEret = 1'b1;
      cyc(1);
      iEret = 1'b0;
   endtask

   task automatic checkExc(input string name, input logic occ, input logic [4:0] code,
                           input logic bd, input logic intr);
      check({name, "_exc"}, 32'(oExcOccurred), 32'(occ));
      check({name, "_code"}, 32'(oExcCode), 32'(code));
      check({name, "_bd"}, 32'(oBranchDelay), 32'(bd));
      check({name, "_int"}, 32'(oInterrupted), 32'(intr));
   endtask

   initial begin
      iCLR = 1'b1; iIRQ = 8'h00; clearIn();
      cyc(2);
      check("reset_pending", 32'(oPendingInterrupt), 32'h00);
      checkExc("reset", 1'b0, 5'd0, 1'b0, 1'b0);
      iCLR = 1'b0;
      cyc(1);

      // 1: single-cycle pulse reaches pending on the third edge; held level sets once
      iIRQ = 8'h08; cyc(1); iIRQ = 8'h00;
      check("t1_lat1", 32'(oPendingInterrupt), 32'h00);
      cyc(1);
      check("t1_lat2", 32'(oPendingInterrupt), 32'h00);
      cyc(1);
      check("t1_lat3", 32'(oPendingInterrupt), 32'h08);
      iIRQAck = 8'h08; cyc(1); iIRQAck = 8'h00;
      check("t1_ack", 32'(oPendingInterrupt), 32'h00);
      iIRQ = 8'h08; cyc(4);
      check("t1_hold_set", 32'(oPendingInterrupt), 32'h08);
      iIRQAck = 8'h08; cyc(1); iIRQAck = 8'h00;
      cyc(5);
      check("t1_hold_once", 32'(oPendingInterrupt), 32'h00);
      iIRQ = 8'h00; cyc(2);
      iIRQ = 8'h20; cyc(1); iIRQ = 8'h00; cyc(1);
      iIRQAck = 8'h20; cyc(1); iIRQAck = 8'h00;
      check("t1_set_wins", 32'(oPendingInterrupt), 32'h20);
      iIRQAck = 8'h20; cyc(1); iIRQAck = 8'h00;

      // 2: interrupt taken at a boundary, one-cycle pulse, then handler
      iInterruptMask = 8'h08; iInstrBoundary = 1'b1; cyc(1);
      checkExc("t2_take", 1'b1, 5'd0, 1'b0, 1'b1);
      clearIn(); cyc(1);
      checkExc("t2_after", 1'b0, 5'd0, 1'b0, 1'b0);

      // 5: interrupts blocked in handler until eret
      iInterruptMask = 8'hFF; iInstrBoundary = 1'b1; cyc(1);
      check("t5_block1", 32'(oExcOccurred), 32'h0);
      cyc(1);
      check("t5_block2", 32'(oExcOccurred), 32'h0);
      clearIn(); iEret = 1'b1; cyc(1); iEret = 1'b0;
      check("t5_eret", 32'(oExcOccurred), 32'h0);
      iInterruptMask = 8'hFF; iInstrBoundary = 1'b1; cyc(1);
      checkExc("t5_take", 1'b1, 5'd0, 1'b0, 1'b1);
      toIdle();

      // 3: fault priority and BD, including a nested fault from handler
      iOverflow = 1'b1; iSyscall = 1'b1; iBranchDelayIn = 1'b1; cyc(1);
      checkExc("t3_sys", 1'b1, 5'd8, 1'b1, 1'b0);
      clearIn(); cyc(1);
      iOverflow = 1'b1; iSyscall = 1'b1; iAddrErrLoad = 1'b1; iBranchDelayIn = 1'b1; cyc(1);
      checkExc("t3_adel", 1'b1, 5'd4, 1'b1, 1'b0);
      toIdle();

      // 4: fault beats interrupt; interrupt taken after eret
      iOverflow = 1'b1; iInstrBoundary = 1'b1; iInterruptMask = 8'h08; cyc(1);
      checkExc("t4_ov", 1'b1, 5'd12, 1'b0, 1'b0);
      iOverflow = 1'b0; cyc(1);
      check("t4_exc_end", 32'(oExcOccurred), 32'h0);
      iEret = 1'b1; cyc(1);
      check("t4_eret", 32'(oExcOccurred), 32'h0);
      iEret = 1'b0; cyc(1);
      checkExc("t4_int", 1'b1, 5'd0, 1'b0, 1'b1);
      toIdle();
      iInstrBoundary = 1'b1; iInterruptMask = 8'h08; iEret = 1'b1; cyc(1);
      checkExc("t4_int_eret", 1'b1, 5'd0, 1'b0, 1'b1);
      toIdle();

      // 6: asynchronous reset during EXC with everything pending
      iIRQ = 8'hFF; cyc(4);
      check("t6_pend", 32'(oPendingInterrupt), 32'hFF);
      iOverflow = 1'b1; cyc(1); iOverflow = 1'b0;
      check("t6_in_exc", 32'(oExcOccurred), 32'h1);
      #2 iCLR = 1'b1;
      #1;
      check("t6_async_pend", 32'(oPendingInterrupt), 32'h00);
      checkExc("t6_async", 1'b0, 5'd0, 1'b0, 1'b0);
      iIRQ = 8'h00;
      cyc(2);
      iCLR = 1'b0; iInstrBoundary = 1'b1; iInterruptMask = 8'h01; cyc(1);
      checkExc("t6_idle", 1'b1, 5'd0, 1'b0, 1'b1);
      toIdle();

      // Randomized run checked by the model every cycle
      for (int n = 0; n < 3000; n++) begin
         iCLR           = ($urandom_range(0, 399) == 0);
         iIRQ           = iIRQ ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
         iIRQAck        = 8'($urandom) & 8'($urandom) & 8'($urandom);
         iInstrBoundary = ($urandom_range(0, 2) == 0);
         iAddrErrLoad   = ($urandom_range(0, 24) == 0);
         iAddrErrStore  = ($urandom_range(0, 24) == 0);
         iReservedInstr = ($urandom_range(0, 24) == 0);
         iSyscall       = ($urandom_range(0, 24) == 0);
         iBreak         = ($urandom_range(0, 24) == 0);
         iOverflow      = ($urandom_range(0, 24) == 0);
         iBranchDelayIn = 1'($urandom);
         iInterruptMask = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
         iExcLevel      = ($urandom_range(0, 3) == 0);
         iEret          = ($urandom_range(0, 3) == 0);
         cyc(1);
      end
      iCLR = 1'b0; clearIn(); cyc(2);

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
